// File: rtl/display_if.sv
// Bus between the datapath result register and the seven-segment driver.
// The display itself is the slave; whoever supplies data and watches the pins is the master.
`timescale 1ns/1ps
interface display_if;
    logic [32:1] data;
    logic [2:0]  which;
    logic [7:0]  seg;
    logic [10:0] count;
    logic [3:0]  digit;

    modport master (output data, input which, seg, count, digit);
    modport slave  (input data, output which, seg, count, digit);
endinterface

// File: rtl/display.sv
// Eight-digit multiplexed seven-segment driver: a free-running 11-bit prescaler
// steps the active digit every 2048 clocks; digit select and decode are combinational.
`timescale 1ns/1ps
module display (
    input  logic        clk,
    input  logic        rst,
    display_if.slave    bus
);

    logic [10:0] r_count;
    logic [2:0]  r_which;
    logic [3:0]  w_digit;
    logic [7:0]  w_seg;
    logic        w_wrap;

    assign w_wrap = (r_count == 11'd2047);

    // The digit index advances only on the edge where the prescaler rolls over.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 11'd0;
            r_which <= 3'd0;
        end else begin
            r_count <= r_count + 11'd1;
            if (w_wrap) begin
                r_which <= r_which + 3'd1;
            end
        end
    end

    always_comb begin
        w_digit = bus.data[4:1];
        case (r_which)
            3'd0: w_digit = bus.data[4:1];
            3'd1: w_digit = bus.data[8:5];
            3'd2: w_digit = bus.data[12:9];
            3'd3: w_digit = bus.data[16:13];
            3'd4: w_digit = bus.data[20:17];
            3'd5: w_digit = bus.data[24:21];
            3'd6: w_digit = bus.data[28:25];
            3'd7: w_digit = bus.data[32:29];
            default: w_digit = bus.data[4:1];
        endcase
    end

    // Active-low {dp,g,f,e,d,c,b,a}; dp stays dark for every code.
    always_comb begin
        w_seg = 8'hFF;
        case (w_digit)
            4'h0: w_seg = 8'hC0;
            4'h1: w_seg = 8'hF9;
            4'h2: w_seg = 8'hA4;
            4'h3: w_seg = 8'hB0;
            4'h4: w_seg = 8'h99;
            4'h5: w_seg = 8'h92;
            4'h6: w_seg = 8'h82;
            4'h7: w_seg = 8'hF8;
            4'h8: w_seg = 8'h80;
            4'h9: w_seg = 8'h90;
            4'hA: w_seg = 8'h88;
            4'hB: w_seg = 8'h83;
            4'hC: w_seg = 8'hC6;
            4'hD: w_seg = 8'hA1;
            4'hE: w_seg = 8'h86;
            4'hF: w_seg = 8'h8E;
            default: w_seg = 8'hFF;
        endcase
    end

    assign bus.count = r_count;
    assign bus.which = r_which;
    assign bus.digit = w_digit;
    assign bus.seg   = w_seg;

endmodule

// File: tb/tb_display.sv
// Directed bench for the display driver: reset state, full scan frames, a mid-frame
// data change, prescaler wrap, reset mid-scan and a full decode sweep.
`timescale 1ns/1ps
module tb_display;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   badEdges;

    logic [7:0] segTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] frameOneDigits [8] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [3:0] frameTwoDigits [8] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h4, 4'h5, 4'h6, 4'h7};

    display_if bus ();

    display dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Steps n rising edges, sampling at each falling edge; a non-negative expWhich
    // flags any edge where which differs from it.
    task automatic applyStimulus(input int n, input int expWhich);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (expWhich >= 0 && int'(bus.which) != expWhich) begin
                badEdges++;
            end
        end
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        badEdges = 0;
        rst      = 1'b1;
        bus.data = 32'hfedc_ba98;
        applyStimulus(2, -1);
        checkOutput("resetCount", 32'(bus.count), 32'd0);
        checkOutput("resetWhich", 32'(bus.which), 32'd0);
        checkOutput("resetDigit", 32'(bus.digit), 32'h8);
        checkOutput("resetSeg",   32'(bus.seg),   32'h80);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            checkOutput("f1Which", 32'(bus.which), 32'(k));
            checkOutput("f1Digit", 32'(bus.digit), 32'(frameOneDigits[k]));
            checkOutput("f1Seg",   32'(bus.seg),   32'(segTable[frameOneDigits[k]]));
            applyStimulus(2047, k);
            checkOutput("f1CountTop", 32'(bus.count), 32'd2047);
            applyStimulus(1, -1);
            checkOutput("f1CountWrap", 32'(bus.count), 32'd0);
            checkOutput("f1WhichStep", 32'(bus.which), 32'((k + 1) % 8));
        end
        checkOutput("f1WhichStable", 32'(badEdges), 32'd0);

        for (int k = 0; k < 8; k++) begin
            checkOutput("f2Which", 32'(bus.which), 32'(k));
            checkOutput("f2Digit", 32'(bus.digit), 32'(frameTwoDigits[k]));
            checkOutput("f2Seg",   32'(bus.seg),   32'(segTable[frameTwoDigits[k]]));
            if (k == 3) begin
                applyStimulus(500, 3);
                checkOutput("midDigitOld", 32'(bus.digit), 32'hB);
                bus.data = 32'h7654_3210;
                #1;
                checkOutput("midDigitNew", 32'(bus.digit), 32'h3);
                checkOutput("midSegNew",   32'(bus.seg),   32'hB0);
                applyStimulus(1547, 3);
            end else begin
                applyStimulus(2047, k);
            end
            applyStimulus(1, -1);
        end
        checkOutput("f2WhichStable", 32'(badEdges), 32'd0);
        checkOutput("f2WhichWrap",   32'(bus.which), 32'd0);

        applyStimulus(5 * 2048 + 1000, -1);
        checkOutput("preResetWhich", 32'(bus.which), 32'd5);
        checkOutput("preResetCount", 32'(bus.count), 32'd1000);
        rst = 1'b1;
        applyStimulus(1, -1);
        rst = 1'b0;
        checkOutput("midResetCount", 32'(bus.count), 32'd0);
        checkOutput("midResetWhich", 32'(bus.which), 32'd0);
        applyStimulus(2047, 0);
        checkOutput("postResetStable", 32'(badEdges), 32'd0);
        checkOutput("postResetCount",  32'(bus.count), 32'd2047);
        applyStimulus(1, -1);
        checkOutput("postResetStep", 32'(bus.which), 32'd1);

        rst = 1'b1;
        applyStimulus(3, -1);
        checkOutput("heldCount", 32'(bus.count), 32'd0);
        checkOutput("heldWhich", 32'(bus.which), 32'd0);
        for (int n = 0; n < 16; n++) begin
            bus.data = {28'h0, 4'(n)};
            #1;
            checkOutput("sweepDigit", 32'(bus.digit), 32'(n));
            checkOutput("sweepSeg",   32'(bus.seg),   32'(segTable[n]));
        end
        applyStimulus(1, -1);
        checkOutput("sweepWhich", 32'(bus.which), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
